ant_sense_ctrl: RTL and testbench

- Per-ant sensing sequencer. On a start request it latches the ant's X, Y and dir.
- It derives the left, front and right neighbour cells and reads the pheromone level of each from the single-port pheromone memory, one read at a time.
- It then picks the next heading and target cell. It sits between the ant update scheduler and the pheromone memory arbiter.

---
 rtl/ant_sense_ctrl_pkg.sv | 56 +++++
 rtl/ant_front_locs.sv | 30 +++
 rtl/ant_sense_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_ant_sense_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ant_sense_ctrl_pkg.sv
// Shared widths, grid limits, heading encoding and controller states for the ant sensing sequencer.
package ant_sense_ctrl_pkg;

   localparam int X_bits    = 8;
   localparam int Y_bits    = 7;
   localparam int GRID_W    = 160;
   localparam int GRID_H    = 120;
   localparam int PHER_bits = 8;

   // Limits carry one extra bit so a stepped coordinate can be range-checked directly.
   localparam logic [X_bits:0] GRID_W_LIM = (X_bits+1)'(GRID_W);
   localparam logic [Y_bits:0] GRID_H_LIM = (Y_bits+1)'(GRID_H);

   localparam logic [2:0] DIR_N  = 3'd0;
   localparam logic [2:0] DIR_NE = 3'd1;
   localparam logic [2:0] DIR_E  = 3'd2;
   localparam logic [2:0] DIR_SE = 3'd3;
   localparam logic [2:0] DIR_S  = 3'd4;
   localparam logic [2:0] DIR_SW = 3'd5;
   localparam logic [2:0] DIR_W  = 3'd6;
   localparam logic [2:0] DIR_NW = 3'd7;

   localparam logic [1:0] IDX_LEFT  = 2'd0;
   localparam logic [1:0] IDX_FRONT = 2'd1;
   localparam logic [1:0] IDX_RIGHT = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_DECIDE,
      ST_DONE
   } senseState_t;

   // Underflow at column 0 wraps to all-ones in the widened result, which is out of range.
   function automatic logic [X_bits:0] stepX(input logic [X_bits-1:0] x, input logic [2:0] dir);
      logic [X_bits:0] ext;
      ext = {1'b0, x};
      case (dir)
         DIR_NE, DIR_E, DIR_SE: stepX = ext + (X_bits+1)'(1);
         DIR_SW, DIR_W, DIR_NW: stepX = ext - (X_bits+1)'(1);
         default:               stepX = ext;
      endcase
   endfunction

   function automatic logic [Y_bits:0] stepY(input logic [Y_bits-1:0] y, input logic [2:0] dir);
      logic [Y_bits:0] ext;
      ext = {1'b0, y};
      case (dir)
         DIR_N, DIR_NE, DIR_NW: stepY = ext - (Y_bits+1)'(1);
         DIR_SE, DIR_S, DIR_SW: stepY = ext + (Y_bits+1)'(1);
         default:               stepY = ext;
      endcase
   endfunction

endpackage

// File: rtl/ant_front_locs.sv
// Left, front and right neighbour cells of an ant, widened by one bit so that
// both underflow and overflow land outside the grid limits.
module ant_front_locs
   import ant_sense_ctrl_pkg::*;
(
   input  logic [X_bits-1:0] posX_i,
   input  logic [Y_bits-1:0] posY_i,
   input  logic [2:0]        dir_i,
   output logic [X_bits:0]   leftX_o,
   output logic [Y_bits:0]   leftY_o,
   output logic [X_bits:0]   frontX_o,
   output logic [Y_bits:0]   frontY_o,
   output logic [X_bits:0]   rightX_o,
   output logic [Y_bits:0]   rightY_o
);

   logic [2:0] leftDir;
   logic [2:0] rightDir;

   assign leftDir  = dir_i - 3'd1;
   assign rightDir = dir_i + 3'd1;

   assign leftX_o  = stepX(posX_i, leftDir);
   assign leftY_o  = stepY(posY_i, leftDir);
   assign frontX_o = stepX(posX_i, dir_i);
   assign frontY_o = stepY(posY_i, dir_i);
   assign rightX_o = stepX(posX_i, rightDir);
   assign rightY_o = stepY(posY_i, rightDir);

endmodule

// File: rtl/ant_sense_ctrl.sv
// Per-ant sensing sequencer: reads the left/front/right pheromone one cell at a time and picks the next heading.
// Build option: define SENSE_RANDOM_TIE_EN for LFSR-based tie breaking instead of front > left > right.
module ant_sense_ctrl
   import ant_sense_ctrl_pkg::*;
(
   input  logic                 Clk,
   input  logic                 Reset_n,
   input  logic                 start,
   input  logic [X_bits-1:0]    ant_X,
   input  logic [Y_bits-1:0]    ant_Y,
   input  logic [2:0]           ant_dir,
   output logic                 busy,
   output logic                 done,
   output logic [2:0]           new_dir,
   output logic [X_bits-1:0]    move_X,
   output logic [Y_bits-1:0]    move_Y,
   output logic                 mem_rd,
   output logic [X_bits-1:0]    mem_X,
   output logic [Y_bits-1:0]    mem_Y,
   input  logic                 mem_rvalid,
   input  logic [PHER_bits-1:0] mem_rdata
);

   localparam logic [1:0] PICK_NONE = 2'd3;

   senseState_t          state_q, state_d;
   logic [1:0]           idx_q, idx_d;
   logic [X_bits-1:0]    latX_q;
   logic [Y_bits-1:0]    latY_q;
   logic [2:0]           latDir_q;
   logic [PHER_bits-1:0] sample_q [3];
   logic [2:0]           blocked_q;
   logic [2:0]           newDir_q;
   logic [X_bits-1:0]    moveX_q;
   logic [Y_bits-1:0]    moveY_q;

   logic [X_bits:0]      leftX, frontX, rightX, cellX;
   logic [Y_bits:0]      leftY, frontY, rightY, cellY;
   logic                 cellInBounds;

   logic [PHER_bits-1:0] maxVal;
   logic [2:0]           tied;
   logic [1:0]           pick;
   logic [2:0]           decDir;
   logic [X_bits-1:0]    decX;
   logic [Y_bits-1:0]    decY;

   ant_front_locs uFrontLocs (
      .posX_i   (latX_q),
      .posY_i   (latY_q),
      .dir_i    (latDir_q),
      .leftX_o  (leftX),
      .leftY_o  (leftY),
      .frontX_o (frontX),
      .frontY_o (frontY),
      .rightX_o (rightX),
      .rightY_o (rightY)
   );

   always_comb begin
      cellX = frontX;
      cellY = frontY;
      case (idx_q)
         IDX_LEFT: begin
            cellX = leftX;
            cellY = leftY;
         end
         IDX_RIGHT: begin
            cellX = rightX;
            cellY = rightY;
         end
         default: begin
            cellX = frontX;
            cellY = frontY;
         end
      endcase
   end

   assign cellInBounds = (cellX < GRID_W_LIM) && (cellY < GRID_H_LIM);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= ST_IDLE;
         idx_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Blocked cells skip the read entirely, so ISSUE may repeat on consecutive cycles.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      mem_rd  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_ISSUE;
               idx_d   = IDX_LEFT;
            end
         end
         ST_ISSUE: begin
            if (cellInBounds) begin
               mem_rd  = 1'b1;
               state_d = ST_WAIT;
            end else if (idx_q == IDX_RIGHT) begin
               state_d = ST_DECIDE;
            end else begin
               idx_d = idx_q + 2'd1;
            end
         end
         ST_WAIT: begin
            if (mem_rvalid) begin
               if (idx_q == IDX_RIGHT) begin
                  state_d = ST_DECIDE;
               end else begin
                  idx_d   = idx_q + 2'd1;
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_DECIDE: state_d = ST_DONE;
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   assign busy    = (state_q != ST_IDLE);
   assign done    = (state_q == ST_DONE);
   assign mem_X   = mem_rd ? cellX[X_bits-1:0] : '0;
   assign mem_Y   = mem_rd ? cellY[Y_bits-1:0] : '0;
   assign new_dir = newDir_q;
   assign move_X  = moveX_q;
   assign move_Y  = moveY_q;

`ifdef SENSE_RANDOM_TIE_EN
   logic [7:0] lfsr_q;
   logic [1:0] tieCount;
   logic [1:0] tieSel;
   logic [1:0] seen;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         lfsr_q <= 8'hA5;
      end else begin
         lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      end
   end
`endif

   // Blocked cells are excluded from the maximum; an open cell reading zero still competes.
   always_comb begin
      maxVal = '0;
      for (int i = 0; i < 3; i++) begin
         if (!blocked_q[i] && (sample_q[i] > maxVal)) maxVal = sample_q[i];
      end
      for (int i = 0; i < 3; i++) begin
         tied[i] = !blocked_q[i] && (sample_q[i] == maxVal);
      end
      pick = PICK_NONE;
`ifdef SENSE_RANDOM_TIE_EN
      tieCount = 2'(tied[0]) + 2'(tied[1]) + 2'(tied[2]);
      case (tieCount)
         2'd2:    tieSel = {1'b0, lfsr_q[0]};
         2'd3:    tieSel = (lfsr_q[1:0] == 2'd3) ? 2'd0 : lfsr_q[1:0];
         default: tieSel = 2'd0;
      endcase
      seen = 2'd0;
      for (int i = 0; i < 3; i++) begin
         if (tied[i]) begin
            if ((seen == tieSel) && (pick == PICK_NONE)) pick = 2'(i);
            seen = seen + 2'd1;
         end
      end
`else
      if (tied[IDX_FRONT]) begin
         pick = IDX_FRONT;
      end else if (tied[IDX_LEFT]) begin
         pick = IDX_LEFT;
      end else if (tied[IDX_RIGHT]) begin
         pick = IDX_RIGHT;
      end
`endif
      decDir = latDir_q + 3'd4;
      decX   = latX_q;
      decY   = latY_q;
      case (pick)
         IDX_LEFT: begin
            decDir = latDir_q - 3'd1;
            decX   = leftX[X_bits-1:0];
            decY   = leftY[Y_bits-1:0];
         end
         IDX_FRONT: begin
            decDir = latDir_q;
            decX   = frontX[X_bits-1:0];
            decY   = frontY[Y_bits-1:0];
         end
         IDX_RIGHT: begin
            decDir = latDir_q + 3'd1;
            decX   = rightX[X_bits-1:0];
            decY   = rightY[Y_bits-1:0];
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         latX_q    <= '0;
         latY_q    <= '0;
         latDir_q  <= '0;
         sample_q  <= '{default: '0};
         blocked_q <= '0;
         newDir_q  <= '0;
         moveX_q   <= '0;
         moveY_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  latX_q    <= ant_X;
                  latY_q    <= ant_Y;
                  latDir_q  <= ant_dir;
                  blocked_q <= '0;
               end
            end
            ST_ISSUE: begin
               blocked_q[idx_q] <= !cellInBounds;
               if (!cellInBounds) sample_q[idx_q] <= '0;
            end
            ST_WAIT: begin
               if (mem_rvalid) sample_q[idx_q] <= mem_rdata;
            end
            ST_DECIDE: begin
               newDir_q <= decDir;
               moveX_q  <= decX;
               moveY_q  <= decY;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ant_sense_ctrl.sv
// Scoreboard bench for ant_sense_ctrl: expected reads and results are queued at stimulus time
// and popped by independent memory-responder and done-monitor processes.
module tb_ant_sense_ctrl;

   localparam int GW = 160;
   localparam int GH = 120;

   logic       Clk = 1'b0;
   logic       Reset_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] ant_X = '0;
   logic [6:0] ant_Y = '0;
   logic [2:0] ant_dir = '0;
   logic       busy, done, mem_rd;
   logic [2:0] new_dir;
   logic [7:0] move_X, mem_X;
   logic [6:0] move_Y, mem_Y;
   logic       mem_rvalid = 1'b0;
   logic [7:0] mem_rdata = '0;

   typedef struct { int x; int y; int delay; } rdExp_t;
   typedef struct { int dir; int x; int y; int lat; int startEdge; } resExp_t;

   rdExp_t  expReadQ[$];
   resExp_t expQ[$];

   int checks = 0;
   int failures = 0;
   int cycleCount = 0;
   bit strayReq = 1'b0;
   int pherMap [GW][GH];
   int dxTab [8] = '{0, 1, 1, 1, 0, -1, -1, -1};
   int dyTab [8] = '{-1, -1, 0, 1, 1, 1, 0, -1};

   ant_sense_ctrl dut (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .start      (start),
      .ant_X      (ant_X),
      .ant_Y      (ant_Y),
      .ant_dir    (ant_dir),
      .busy       (busy),
      .done       (done),
      .new_dir    (new_dir),
      .move_X     (move_X),
      .move_Y     (move_Y),
      .mem_rd     (mem_rd),
      .mem_X      (mem_X),
      .mem_Y      (mem_Y),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) cycleCount <= cycleCount + 1;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Reference model: neighbours from heading offsets, open cells compared by sample, front > left > right on ties.
   task automatic applyStimulus(input int x, input int y, input int dir,
                                input int dl, input int df, input int dr);
      int      delays [3];
      int      nd [3];
      int      nx [3];
      int      ny [3];
      bit      ok [3];
      int      prefOrder [3];
      int      best;
      int      bestS;
      int      k;
      resExp_t e;
      rdExp_t  r;
      delays    = '{dl, df, dr};
      prefOrder = '{1, 0, 2};
      e.lat = 5;
      for (int i = 0; i < 3; i++) begin
         nd[i] = (dir + i + 7) % 8;
         nx[i] = x + dxTab[nd[i]];
         ny[i] = y + dyTab[nd[i]];
         ok[i] = (nx[i] >= 0) && (nx[i] < GW) && (ny[i] >= 0) && (ny[i] < GH);
         if (ok[i]) begin
            r.x = nx[i];
            r.y = ny[i];
            r.delay = delays[i];
            expReadQ.push_back(r);
            e.lat += delays[i];
         end
      end
      best  = -1;
      bestS = -1;
      for (int j = 0; j < 3; j++) begin
         k = prefOrder[j];
         if (ok[k] && pherMap[nx[k]][ny[k]] > bestS) begin
            best  = k;
            bestS = pherMap[nx[k]][ny[k]];
         end
      end
      if (best < 0) begin
         e.dir = (dir + 4) % 8;
         e.x   = x;
         e.y   = y;
      end else begin
         e.dir = nd[best];
         e.x   = nx[best];
         e.y   = ny[best];
      end
      ant_X   = 8'(x);
      ant_Y   = 7'(y);
      ant_dir = 3'(dir);
      start   = 1'b1;
      e.startEdge = cycleCount + 1;
      expQ.push_back(e);
      @(negedge Clk);
      start = 1'b0;
   endtask

   task automatic waitDone();
      int n;
      n = 0;
      while (expQ.size() != 0 && n < 300) begin
         @(negedge Clk);
         n++;
      end
      checks++;
      if (expQ.size() != 0) begin
         failures++;
         $display("[TB] FAIL done_timeout: got no done after %0d cycles, expected done", n);
         expQ.delete();
         expReadQ.delete();
      end
      @(negedge Clk);
   endtask

   function automatic int edgeBiased(input int limit);
      int r;
      r = $urandom_range(0, 3);
      if (r == 0) return 0;
      if (r == 1) return limit - 1;
      return $urandom_range(0, limit - 1);
   endfunction

   // Memory model: checks each read address and answers after the queued delay.
   initial begin : memResponder
      int         countdown;
      logic [7:0] pending;
      rdExp_t     r;
      countdown = 0;
      pending   = '0;
      forever begin
         @(negedge Clk);
         mem_rvalid = 1'b0;
         if (!Reset_n) begin
            countdown = 0;
         end else begin
            if (countdown > 0) begin
               countdown--;
               if (countdown == 0) begin
                  mem_rvalid = 1'b1;
                  mem_rdata  = pending;
               end
            end
            if (strayReq) begin
               mem_rvalid = 1'b1;
               mem_rdata  = 8'hFF;
               strayReq   = 1'b0;
            end
            if (mem_rd) begin
               if (expReadQ.size() == 0) begin
                  checks++;
                  failures++;
                  $display("[TB] FAIL unexpected_read: got read at (%0d,%0d), expected none", mem_X, mem_Y);
               end else begin
                  r = expReadQ.pop_front();
                  checkOutput("mem_X", int'(mem_X), r.x);
                  checkOutput("mem_Y", int'(mem_Y), r.y);
                  countdown = r.delay;
               end
               pending = (mem_X < GW && mem_Y < GH) ? 8'(pherMap[mem_X][mem_Y]) : 8'h00;
            end
         end
      end
   end

   initial begin : doneMonitor
      resExp_t e;
      forever begin
         @(negedge Clk);
         if (Reset_n && done) begin
            if (expQ.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_done: got done=1, expected 0");
            end else begin
               e = expQ.pop_front();
               checkOutput("new_dir", int'(new_dir), e.dir);
               checkOutput("move_X", int'(move_X), e.x);
               checkOutput("move_Y", int'(move_Y), e.y);
               checkOutput("latency", cycleCount + 1 - e.startEdge, e.lat);
            end
         end
      end
   end

   initial begin : watchdog
      #3000000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : mainFlow
      for (int x = 0; x < GW; x++)
         for (int y = 0; y < GH; y++)
            pherMap[x][y] = $urandom_range(0, 3);

      #1;
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_done", int'(done), 0);
      checkOutput("reset_mem_rd", int'(mem_rd), 0);
      checkOutput("reset_mem_X", int'(mem_X), 0);
      checkOutput("reset_mem_Y", int'(mem_Y), 0);
      checkOutput("reset_new_dir", int'(new_dir), 0);
      checkOutput("reset_move_X", int'(move_X), 0);
      checkOutput("reset_move_Y", int'(move_Y), 0);
      repeat (2) @(negedge Clk);
      Reset_n = 1'b1;
      @(negedge Clk);

      pherMap[49][39] = 3; pherMap[50][39] = 7; pherMap[51][39] = 5;
      applyStimulus(50, 40, 0, 1, 1, 1);
      checkOutput("busy_after_start", int'(busy), 1);
      waitDone();

      pherMap[51][39] = 9; pherMap[51][40] = 9; pherMap[51][41] = 2;
      applyStimulus(50, 40, 2, 1, 1, 1);
      waitDone();

      applyStimulus(0, 0, 7, 1, 1, 1);
      waitDone();
      applyStimulus(0, 0, 0, 1, 1, 1);
      waitDone();
      applyStimulus(GW - 1, GH - 1, 3, 1, 1, 1);
      waitDone();
      applyStimulus(GW - 1, 60, 2, 2, 2, 2);
      waitDone();

      pherMap[49][39] = 3; pherMap[50][39] = 7; pherMap[51][39] = 5;
      applyStimulus(50, 40, 0, 1, 4, 1);
      repeat (3) @(negedge Clk);
      ant_X   = 8'd9;
      ant_dir = 3'd3;
      start   = 1'b1;
      @(negedge Clk);
      start = 1'b0;
      waitDone();

      for (int t = 0; t < 40; t++) begin
         applyStimulus(edgeBiased(GW), edgeBiased(GH), $urandom_range(0, 7),
                       $urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 3));
         waitDone();
      end

      applyStimulus(80, 60, 3, 6, 1, 1);
      repeat (2) @(negedge Clk);
      checkOutput("busy_in_wait", int'(busy), 1);
      #2;
      Reset_n = 1'b0;
      #1;
      checkOutput("abort_busy", int'(busy), 0);
      checkOutput("abort_mem_rd", int'(mem_rd), 0);
      checkOutput("abort_new_dir", int'(new_dir), 0);
      checkOutput("abort_move_X", int'(move_X), 0);
      expQ.delete();
      expReadQ.delete();
      repeat (2) @(negedge Clk);
      Reset_n  = 1'b1;
      strayReq = 1'b1;
      repeat (6) @(negedge Clk);
      checkOutput("stray_rvalid_busy", int'(busy), 0);
      applyStimulus(80, 60, 3, 1, 2, 1);
      waitDone();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
